// File: rtl/io_input_conditioner.sv
`default_nettype none
// ============================================================================
// Module   : io_input_conditioner
// Purpose  : Synchronises raw board switches and buttons into the core clock
//            domain, debounces every bit against a shared sample tick,
//            normalises button polarity and keeps sticky press-event flags
//            that software clears with a write-1-to-clear vector.
// Revision : 1.0  initial release
// ============================================================================
module io_input_conditioner #(
    parameter int SW_W           = 32,
    parameter int BTN_W          = 32,
    parameter int TICK_CYCLES    = 50000,
    parameter int STABLE_TICKS   = 8,
    parameter int BTN_ACTIVE_LOW = 1
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic [SW_W-1:0]  i_sw_raw,
    input  logic [BTN_W-1:0] i_btn_raw,
    input  logic [BTN_W-1:0] i_evt_clr,
    output logic [SW_W-1:0]  o_io_sw,
    output logic [BTN_W-1:0] o_io_btn,
    output logic [BTN_W-1:0] o_btn_evt,
    output logic             o_evt_any,
    output logic             o_tick
);

    // Switches and buttons share one debouncer array: switches occupy the
    // low SW_W bits, buttons the BTN_W bits above them.
    localparam int N_BITS = SW_W + BTN_W;
    localparam int PRE_W  = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
    localparam int DB_W   = $clog2(STABLE_TICKS + 1);

    localparam logic [PRE_W-1:0] c_pre_last = PRE_W'(TICK_CYCLES - 1);
    localparam logic [DB_W-1:0]  c_db_last  = DB_W'(STABLE_TICKS - 1);
    localparam logic [BTN_W-1:0] c_btn_inv  =
        (BTN_ACTIVE_LOW != 0) ? {BTN_W{1'b1}} : {BTN_W{1'b0}};

    logic [BTN_W-1:0]  w_btn_norm;
    logic [SW_W-1:0]   r_sw_meta;
    logic [SW_W-1:0]   r_sw_sync;
    logic [BTN_W-1:0]  r_btn_meta;
    logic [BTN_W-1:0]  r_btn_sync;
    logic [PRE_W-1:0]  r_pre;
    logic              w_tick;
    logic [N_BITS-1:0] w_db_in;
    logic [N_BITS-1:0] w_db_level;
    logic [N_BITS-1:0] w_db_accept;
    logic [BTN_W-1:0]  w_btn_rise;
    logic [BTN_W-1:0]  r_evt;

    // Buttons are flipped to 1 = pressed before they enter the synchroniser.
    assign w_btn_norm = i_btn_raw ^ c_btn_inv;

    // Two-flop synchronisers for both raw vectors.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sw_meta  <= '0;
            r_sw_sync  <= '0;
            r_btn_meta <= '0;
            r_btn_sync <= '0;
        end else begin
            r_sw_meta  <= i_sw_raw;
            r_sw_sync  <= r_sw_meta;
            r_btn_meta <= w_btn_norm;
            r_btn_sync <= r_btn_meta;
        end
    end

    // Free-running prescaler; the tick is a decode of its terminal count.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_pre <= '0;
        end else if (r_pre == c_pre_last) begin
            r_pre <= '0;
        end else begin
            r_pre <= r_pre + PRE_W'(1);
        end
    end

    assign w_tick  = (r_pre == c_pre_last);
    assign w_db_in = {r_btn_sync, r_sw_sync};

    generate
        for (genvar i = 0; i < N_BITS; i++) begin : g_db
            logic            r_level;
            logic [DB_W-1:0] r_cnt;

            // A level change is accepted on the tick that completes the run
            // of consecutive differing samples.
            assign w_db_accept[i] = w_tick && (w_db_in[i] != r_level) &&
                                    (r_cnt == c_db_last);
            assign w_db_level[i]  = r_level;

            // Count consecutive ticks that see the new level; any tick that
            // sees the held level restarts the run.
            always_ff @(posedge i_clk or negedge i_rst_n) begin
                if (!i_rst_n) begin
                    r_level <= 1'b0;
                    r_cnt   <= '0;
                end else if (w_tick) begin
                    if (w_db_in[i] == r_level) begin
                        r_cnt <= '0;
                    end else if (r_cnt == c_db_last) begin
                        r_level <= w_db_in[i];
                        r_cnt   <= '0;
                    end else begin
                        r_cnt <= r_cnt + DB_W'(1);
                    end
                end
            end
        end
    endgenerate

    // A press is an accepted change whose new level is 1 (held level was 0).
    assign w_btn_rise = w_db_accept[SW_W +: BTN_W] & w_db_in[SW_W +: BTN_W];

    // Sticky press flags; a press on the same edge as a clear keeps the flag.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_evt <= '0;
        end else begin
            r_evt <= (r_evt & ~i_evt_clr) | w_btn_rise;
        end
    end

    assign o_io_sw   = w_db_level[SW_W-1:0];
    assign o_io_btn  = w_db_level[SW_W +: BTN_W];
    assign o_btn_evt = r_evt;
    assign o_evt_any = |r_evt;
    assign o_tick    = w_tick;

endmodule
`default_nettype wire

// File: tb/tb_io_input_conditioner.sv
`default_nettype none
// ============================================================================
// Module   : tb_io_input_conditioner
// Purpose  : Directed self-checking bench for io_input_conditioner with
//            TICK_CYCLES=4, STABLE_TICKS=3, BTN_ACTIVE_LOW=1.
// Revision : 1.0  initial release
// ============================================================================
module tb_io_input_conditioner;

    logic        clk;
    logic        rst_n;
    logic [31:0] sw_raw;
    logic [31:0] btn_raw;
    logic [31:0] evt_clr;
    logic [31:0] io_sw;
    logic [31:0] io_btn;
    logic [31:0] btn_evt;
    logic        evt_any;
    logic        tick;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;   // posedges since the most recent reset release
    int n;
    bit found;

    io_input_conditioner #(
        .SW_W          (32),
        .BTN_W         (32),
        .TICK_CYCLES   (4),
        .STABLE_TICKS  (3),
        .BTN_ACTIVE_LOW(1)
    ) dut (
        .i_clk    (clk),
        .i_rst_n  (rst_n),
        .i_sw_raw (sw_raw),
        .i_btn_raw(btn_raw),
        .i_evt_clr(evt_clr),
        .o_io_sw  (io_sw),
        .o_io_btn (io_btn),
        .o_btn_evt(btn_evt),
        .o_evt_any(evt_any),
        .o_tick   (tick)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Inputs are driven and outputs sampled on the falling edge.
    task automatic step();
        @(negedge clk);
        cyc++;
    endtask

    task automatic align4();
        while ((cyc % 4) != 0) step();
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_sw"},   io_sw,   32'h0);
        chk({tag, "_btn"},  io_btn,  32'h0);
        chk({tag, "_evt"},  btn_evt, 32'h0);
        chk({tag, "_any"},  {31'b0, evt_any}, 32'h0);
        chk({tag, "_tick"}, {31'b0, tick},    32'h0);
    endtask

    initial begin
        rst_n   = 1'b0;
        sw_raw  = 32'h0;
        btn_raw = 32'hFFFF_FFFF;
        evt_clr = 32'h0;

        // ---- reset state and idle behaviour ----
        repeat (3) @(negedge clk);
        chk_all_zero("reset");
        rst_n = 1'b1;
        cyc   = 0;
        for (int k = 0; k < 50; k++) begin
            step();
            chk("idle_sw",  io_sw,   32'h0);
            chk("idle_btn", io_btn,  32'h0);
            chk("idle_evt", btn_evt, 32'h0);
            chk("idle_any", {31'b0, evt_any}, 32'h0);
            chk("idle_tick", {31'b0, tick}, 32'((cyc % 4) == 3));
        end

        // ---- switch 0 rises and is held ----
        sw_raw[0] = 1'b1;
        n = 0; found = 1'b0;
        while (!found && n < 20) begin
            step(); n++;
            if (io_sw[0]) found = 1'b1;
            else chk("sw0_early", io_sw, 32'h0);
        end
        chk("sw0_found", {31'b0, found}, 32'h1);
        chk("sw0_latency_11_to_14", 32'(n >= 11 && n <= 14), 32'h1);
        chk("sw0_only_bit", io_sw, 32'h1);

        // ---- switch 5 glitches: 5-cycle and 9-cycle pulses ----
        repeat (16) step();
        align4();
        sw_raw[5] = 1'b1;
        repeat (5) begin step(); chk("sw5_pulse5", io_sw, 32'h1); end
        sw_raw[5] = 1'b0;
        repeat (12) begin step(); chk("sw5_after5", io_sw, 32'h1); end
        align4();
        sw_raw[5] = 1'b1;
        repeat (9) begin step(); chk("sw5_pulse9", io_sw, 32'h1); end
        sw_raw[5] = 1'b0;
        repeat (16) begin step(); chk("sw5_after9", io_sw, 32'h1); end

        // ---- button 1 press, release, clear ----
        btn_raw[1] = 1'b0;
        n = 0; found = 1'b0;
        while (!found && n < 20) begin
            step(); n++;
            if (io_btn[1]) found = 1'b1;
            else chk("btn1_evt_early", btn_evt, 32'h0);
        end
        chk("btn1_found", {31'b0, found}, 32'h1);
        chk("btn1_latency_11_to_14", 32'(n >= 11 && n <= 14), 32'h1);
        chk("btn1_level", io_btn, 32'h2);
        chk("btn1_evt_same_cycle", btn_evt, 32'h2);
        chk("btn1_any", {31'b0, evt_any}, 32'h1);
        btn_raw[1] = 1'b1;
        n = 0; found = 1'b0;
        while (!found && n < 20) begin
            step(); n++;
            if (!io_btn[1]) found = 1'b1;
        end
        chk("btn1_release_found", {31'b0, found}, 32'h1);
        chk("btn1_released", io_btn, 32'h0);
        chk("btn1_evt_sticky", btn_evt, 32'h2);
        chk("btn1_any_sticky", {31'b0, evt_any}, 32'h1);
        evt_clr[1] = 1'b1;
        step();
        evt_clr[1] = 1'b0;
        chk("btn1_evt_cleared", btn_evt, 32'h0);
        chk("btn1_any_cleared", {31'b0, evt_any}, 32'h0);

        // ---- button 2 press with clear held across the rising edge ----
        btn_raw[2] = 1'b0;
        evt_clr[2] = 1'b1;
        n = 0; found = 1'b0;
        while (!found && n < 20) begin
            step(); n++;
            if (io_btn[2]) found = 1'b1;
        end
        chk("btn2_found", {31'b0, found}, 32'h1);
        chk("btn2_set_wins", btn_evt, 32'h4);
        evt_clr[2] = 1'b0;
        step();
        chk("btn2_evt_holds", btn_evt, 32'h4);
        btn_raw[2] = 1'b1;
        evt_clr[2] = 1'b1;
        step();
        evt_clr[2] = 1'b0;
        chk("btn2_evt_cleared", btn_evt, 32'h0);
        repeat (16) step();
        chk("btn2_released", io_btn, 32'h0);

        // ---- reset in the middle of a pending switch 3 change ----
        align4();
        sw_raw[3] = 1'b1;
        repeat (9) begin step(); chk("sw3_pending", io_sw, 32'h1); end
        rst_n = 1'b0;
        #1;
        chk_all_zero("midreset");
        @(negedge clk);
        chk_all_zero("midreset_hold");
        rst_n = 1'b1;
        cyc   = 0;
        for (int k = 0; k < 16; k++) begin
            step();
            chk("resync_sw", io_sw, (cyc >= 12) ? 32'h9 : 32'h0);
            chk("resync_btn", io_btn, 32'h0);
            chk("resync_tick", {31'b0, tick}, 32'((cyc % 4) == 3));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/io_input_conditioner.md
# io_input_conditioner

Input conditioning stage directly upstream of the pipelined core's `i_io_sw` / `i_io_btn` ports. It synchronises the raw board switches and push-buttons into the core clock domain and debounces each bit against a shared sample tick. It normalises button polarity and keeps sticky per-button press-event flags that software clears through a write-1-to-clear vector. The core reads its outputs through the LSU input-peripheral addresses.

## Interface
- `SW_W`, 32, switch vector width.
- `BTN_W`, 32, button vector width.
- `TICK_CYCLES`, 50000, clocks per debounce sample tick (1 ms at 50 MHz); legal ≥ 2.
- `STABLE_TICKS`, 8, consecutive differing ticks needed to accept a change; legal ≥ 1.
- `BTN_ACTIVE_LOW`, 1, 1 = raw button low means pressed.

Ports:
- `i_clk`  in  1  sole clock.
- `i_rst_n`  in  1  reset, asynchronous, active-low.
- `i_sw_raw`  in  SW_W  raw asynchronous switches, active-high.
- `i_btn_raw`  in  BTN_W  raw asynchronous buttons.
- `i_evt_clr`  in  BTN_W  write-1-to-clear for `o_btn_evt`, synchronous.
- `o_io_sw`  out  SW_W  debounced switch levels (to core `i_io_sw`).
- `o_io_btn`  out  BTN_W  debounced buttons, 1 = pressed (to core `i_io_btn`).
- `o_btn_evt`  out  BTN_W  sticky press flags.
- `o_evt_any`  out  1  OR-reduction of `o_btn_evt`.
- `o_tick`  out  1  debounce sample strobe, for observation only.

## Operation
- Normalise: `btn_n = i_btn_raw ^ {BTN_W{BTN_ACTIVE_LOW}}`. Switches pass through unchanged.
- Synchronise: two-flop synchroniser per bit on both vectors, after normalisation.
- Prescaler: counts 0..TICK_CYCLES-1 and wraps to 0. `o_tick` = 1 for the single cycle where count == TICK_CYCLES-1.
- Per-bit debouncer: holds a stable level `s` and a counter `c` (width clog2(STABLE_TICKS+1)).
- Debouncer on a tick cycle:
  - If synced == s: c <= 0.
  - Else if c+1 == STABLE_TICKS: s <= synced, c <= 0.
  - Else: c <= c+1.
- Debouncer on a non-tick cycle: `s` and `c` hold.
- Result: a change is accepted only after STABLE_TICKS consecutive ticks that all see the new level. Any tick that sees the old level restarts the count.
- `o_io_sw` is the switch `s`. `o_io_btn` is the button `s`.
- Event set: the button `s` goes 0->1 at a clock edge → `o_btn_evt[i]` set at the same edge. `o_io_btn[i]` and `o_btn_evt[i]` rise in the same cycle.
- Event clear: `i_evt_clr[i]` = 1 → `o_btn_evt[i]` cleared at the next edge.
- Set and clear on the same edge: set wins.
- Release (1->0) sets no flag.

## Timing
- Reset values:
  - `o_io_sw`, `o_io_btn`, `o_btn_evt`: 0.
  - `o_evt_any`, `o_tick`: 0.
  - Synchroniser flops: 0.
  - Prescaler and all debounce counters: 0.
- Reset asserted mid-debounce: everything returns to the reset values immediately. After release, the prescaler restarts from 0. The first tick is at cycle TICK_CYCLES-1 after release.
- Synchroniser latency: 2 clocks.
- Acceptance latency, measured from a raw edge: between 2+(STABLE_TICKS-1)·TICK_CYCLES+1 and 2+STABLE_TICKS·TICK_CYCLES clocks.
- The input must stay stable over that whole window for the change to be accepted.
- All outputs are registered except `o_evt_any` and `o_tick`. Both are combinational decodes of registers, so there is no combinational path from any input.
- STABLE_TICKS = 1: accept on the first tick that sees the differing level.
- Prescaler wrap: the tick recurs exactly every TICK_CYCLES clocks, with no drift.

## Test plan
Bench parameters for all scenarios: TICK_CYCLES=4, STABLE_TICKS=3, BTN_ACTIVE_LOW=1.
- Reset with `i_btn_raw` = all-ones and `i_sw_raw` = 0 → all outputs 0, and they stay 0 for 50 cycles. `o_tick` pulses every 4th cycle, first at cycle 3 after release.
- `i_sw_raw[0]` 0→1 and held → `o_io_sw[0]` = 1 within cycles 11..14 after the edge. No other bit changes.
- `i_sw_raw[5]` high for 5 cycles, then low → `o_io_sw[5]` never changes. A second pulse of 9 cycles, also aligned so it spans at most two ticks, → `o_io_sw[5]` still never changes.
- `i_btn_raw[1]` 1→0 and held → `o_io_btn[1]` and `o_btn_evt[1]` both rise in the same cycle, and `o_evt_any` = 1. Then release the button → `o_io_btn[1]` falls and `o_btn_evt[1]` stays 1. Then pulse `i_evt_clr[1]` → `o_btn_evt[1]` = 0 on the next cycle.
- Drive `i_evt_clr[2]` = 1 on the exact cycle `o_io_btn[2]` rises → `o_btn_evt[2]` = 1, because set wins.
- Assert `i_rst_n` low for 1 cycle after 2 ticks of a pending `i_sw_raw[3]` change → all outputs 0. With the input still high, `o_io_sw[3]` rises 3 full ticks after reset release, not 1.
